// File: rtl/pkt_pkg.sv
// Shared types and defaults for the byte-serial packet RX parser.
package pkt_pkg;

  // Parser FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_OUT     = 3'd4
  } pkt_state_e;

  // Header fields captured between SOF and the payload
  typedef struct packed {
    logic [7:0] dest;
    logic [7:0] src;
    logic [7:0] cmd;
    logic [7:0] seq;
  } pkt_hdr_t;

  localparam logic [7:0] SOF_BYTE = 8'h96;
  localparam logic [7:0] BCAST_ID = 8'hFF;
  localparam logic [7:0] CMD_DATA = 8'h01;
  localparam logic [7:0] CMD_KILL = 8'h0F;

  // SOF + DEST + SRC + CMD + SEQ + payload + CHK
  function automatic int unsigned frame_len(input int unsigned payload_bytes);
    return payload_bytes + 32'd6;
  endfunction

endpackage

// File: rtl/pkt_timeout_cnt.sv
// Inter-byte timeout counter. Clear reloads zero, enable counts one idle
// cycle, expire fires on the LIMIT-th consecutive enabled cycle.
module pkt_timeout_cnt #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_en && !i_clr && (r_cnt == LAST);

  // Count idle cycles; restart from zero on clear or after expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pkt_rx_parser.sv
// Byte-serial RX frame parser: SOF hunt, ID/broadcast filter, XOR checksum,
// kill latch, saturating error counter and backpressured payload delivery.
// Optional duplicate-sequence filter enabled by macro PKT_SEQ_FILTER_EN.
module pkt_rx_parser #(
  parameter int unsigned PAYLOAD_BYTES = 2,
  parameter logic [7:0]  SOF_BYTE      = pkt_pkg::SOF_BYTE,
  parameter logic [7:0]  BCAST_ID      = pkt_pkg::BCAST_ID,
  parameter logic [7:0]  CMD_DATA      = pkt_pkg::CMD_DATA,
  parameter logic [7:0]  CMD_KILL      = pkt_pkg::CMD_KILL,
  parameter int unsigned TIMEOUT_CYC   = 1024,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 veh_id,
  input  logic [7:0]                 rx_frame,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [8*PAYLOAD_BYTES-1:0] data,
  output logic [7:0]                 data_src,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       kill,
  output logic [ERR_W-1:0]           err_cnt
);

  import pkt_pkg::*;

  localparam int unsigned DATA_W    = 8 * PAYLOAD_BYTES;
  localparam int unsigned FRAME_LEN = frame_len(PAYLOAD_BYTES);
  localparam int unsigned POS_W     = $clog2(FRAME_LEN);
  // r_pos holds the frame index of the byte being waited for (SOF = 0)
  localparam logic [POS_W-1:0] POS_DEST     = POS_W'(1);
  localparam logic [POS_W-1:0] POS_SRC      = POS_W'(2);
  localparam logic [POS_W-1:0] POS_CMD      = POS_W'(3);
  localparam logic [POS_W-1:0] POS_SEQ      = POS_W'(4);
  localparam logic [POS_W-1:0] POS_LAST_PAY = POS_W'(FRAME_LEN - 2);

  pkt_state_e          r_state;
  pkt_state_e          w_state_nxt;
  logic [POS_W-1:0]    r_pos;
  logic [7:0]          r_chk;
  pkt_hdr_t            r_hdr;
  logic [7:0]          r_id;
  logic [DATA_W-1:0]   r_pay;
  logic [DATA_W-1:0]   r_data;
  logic [7:0]          r_data_src;
  logic                r_data_valid;
  logic                r_rx_ready;
  logic                r_kill;
  logic [ERR_W-1:0]    r_err_cnt;

  logic w_acc;
  logic w_active;
  logic w_expire;
  logic w_chk_ok;
  logic w_dest_ok;
  logic w_dup;
  logic w_err_inc;
  logic w_kill_set;
  logic w_load;

  assign w_acc     = rx_valid && r_rx_ready;
  assign w_active  = (r_state == ST_HDR) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
  assign w_chk_ok  = (rx_frame == r_chk);
  assign w_dest_ok = (r_hdr.dest == r_id) || (r_hdr.dest == BCAST_ID);

  pkt_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_acc || !w_active),
    .i_en     (w_active && !w_acc),
    .o_expire (w_expire)
  );

`ifdef PKT_SEQ_FILTER_EN
  logic [7:0] r_last_seq;
  logic       r_seq_vld;

  assign w_dup = r_seq_vld && (r_hdr.seq == r_last_seq);

  // Remember the SEQ of the last delivered data frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_seq <= 8'h00;
      r_seq_vld  <= 1'b0;
    end else if (w_load) begin
      r_last_seq <= r_hdr.seq;
      r_seq_vld  <= 1'b1;
    end else begin
      r_last_seq <= r_last_seq;
      r_seq_vld  <= r_seq_vld;
    end
  end
`else
  logic w_unused_seq;

  assign w_dup        = 1'b0;
  assign w_unused_seq = ^r_hdr.seq;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and frame verdict. Expiry only fires on a cycle with no
  // accepted byte, so a checksum error and a timeout never both count.
  always_comb begin
    w_state_nxt = r_state;
    w_err_inc   = 1'b0;
    w_kill_set  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && (rx_frame == SOF_BYTE)) begin
          w_state_nxt = ST_HDR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_err_inc   = 1'b1;
        end else if (w_acc && (r_pos == POS_SEQ)) begin
          w_state_nxt = ST_PAYLOAD;
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_PAYLOAD: begin
        if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_err_inc   = 1'b1;
        end else if (w_acc && (r_pos == POS_LAST_PAY)) begin
          w_state_nxt = ST_CHK;
        end else begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_CHK: begin
        if (w_expire) begin
          w_state_nxt = ST_IDLE;
          w_err_inc   = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = ST_IDLE;
          if (!w_chk_ok) begin
            w_err_inc = 1'b1;
          end else if (!w_dest_ok) begin
            w_err_inc = 1'b0;
          end else if (r_hdr.cmd == CMD_KILL) begin
            w_kill_set = 1'b1;
          end else if (r_hdr.cmd == CMD_DATA) begin
            if (w_dup) begin
              w_load = 1'b0;
            end else begin
              w_load      = 1'b1;
              w_state_nxt = ST_OUT;
            end
          end else begin
            w_err_inc = 1'b1;
          end
        end else begin
          w_state_nxt = ST_CHK;
        end
      end
      ST_OUT: begin
        if (r_data_valid && data_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Byte capture: running checksum, header fields and payload shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
      r_chk <= 8'h00;
      r_hdr <= '0;
      r_id  <= 8'h00;
      r_pay <= '0;
    end else if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_frame == SOF_BYTE) begin
            r_pos <= POS_DEST;
            r_chk <= rx_frame;
            r_pay <= '0;
          end
        end
        ST_HDR: begin
          r_pos <= r_pos + POS_W'(1);
          r_chk <= r_chk ^ rx_frame;
          case (r_pos)
            POS_DEST: begin
              r_hdr.dest <= rx_frame;
              r_id       <= veh_id;
            end
            POS_SRC: r_hdr.src <= rx_frame;
            POS_CMD: r_hdr.cmd <= rx_frame;
            POS_SEQ: r_hdr.seq <= rx_frame;
            default: r_hdr <= r_hdr;
          endcase
        end
        ST_PAYLOAD: begin
          r_pos <= r_pos + POS_W'(1);
          r_chk <= r_chk ^ rx_frame;
          r_pay <= (r_pay << 4'd8) | DATA_W'(rx_frame);
        end
        default: begin
          r_pos <= r_pos;
        end
      endcase
    end
  end

  // Registered outputs: handshakes, delivered word, kill latch, error count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready   <= 1'b0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_data_src   <= 8'h00;
      r_kill       <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_rx_ready   <= (w_state_nxt != ST_OUT);
      r_data_valid <= (w_state_nxt == ST_OUT);
      if (w_load) begin
        r_data     <= r_pay;
        r_data_src <= r_hdr.src;
      end
      r_kill <= r_kill | w_kill_set;
      if (w_err_inc && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign rx_ready   = r_rx_ready;
  assign data       = r_data;
  assign data_src   = r_data_src;
  assign data_valid = r_data_valid;
  assign kill       = r_kill;
  assign err_cnt    = r_err_cnt;

endmodule
